// File: rtl/ldl_cdc_pkg.sv
// Shared definitions for the ldl toggle-handshake CDC blocks.
//   LDL_CDC_LEVEL_MIN : smallest legal synchroniser depth
//   ldl_cnt_t         : plain unsigned count type used for widths, depths and pointer maths
//   ldl_occ_width()   : bits needed to hold an occupancy of 0..depth
//   ldl_ptr_width()   : bits needed to index depth entries (at least 1)
//   ldl_ptr_inc()     : modulo-depth pointer increment, safe for non-power-of-2 depths
package ldl_cdc_pkg;

    localparam int unsigned LDL_CDC_LEVEL_MIN = 2;

    typedef int unsigned ldl_cnt_t;

    function automatic ldl_cnt_t ldl_occ_width(input ldl_cnt_t depth);
        return ldl_cnt_t'($clog2(depth + 32'd1));
    endfunction

    function automatic ldl_cnt_t ldl_ptr_width(input ldl_cnt_t depth);
        return (depth > 32'd1) ? ldl_cnt_t'($clog2(depth)) : 32'd1;
    endfunction

    // Wraps to zero after depth-1 rather than relying on natural binary rollover.
    function automatic ldl_cnt_t ldl_ptr_inc(input ldl_cnt_t ptr, input ldl_cnt_t depth);
        return ((ptr + 32'd1) >= depth) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/ldl_cdc_sync_v1.sv
// Multi-stage single-bit synchroniser.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input (may be X/metastable at the first stage)
//   q     : synchronised output, LEVEL clock edges after d settles
module ldl_cdc_sync_v1
    import ldl_cdc_pkg::*;
#(
    parameter int unsigned LEVEL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (LEVEL < LDL_CDC_LEVEL_MIN) begin : gen_level_chk
        $fatal(1, "ldl_cdc_sync_v1: LEVEL=%0d is below the minimum of %0d",
               LEVEL, LDL_CDC_LEVEL_MIN);
    end

    // sync_q[0] is the only flop that ever sees d directly.
    logic [LEVEL-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LEVEL-2:0], d};
        end
    end

    assign q = sync_q[LEVEL-1];

endmodule

// File: rtl/ldl_cdc_tog_rx_v1.sv
// Receive end of a two-phase toggle CDC handshake, entirely in the rx_clk domain.
// The far end toggles tx_st while holding din; once the synchronised request has
// been written into the local buffer, rx_st is toggled to match as the ack. A full
// buffer simply withholds the ack, so back-pressure reaches the tx side instead of
// data being overwritten.
//   rx_clk   : sole clock
//   rx_rst   : asynchronous active-low reset
//   tx_st    : request toggle from the tx domain (asynchronous)
//   din      : tx-held data word, stable while a request is outstanding
//   rx_st    : ack toggle back to the tx domain
//   dout     : head-of-buffer word
//   dout_vld : buffer non-empty
//   dout_rdy : downstream takes dout this cycle
//   busy     : request seen but not yet acked
//   level    : buffer occupancy
module ldl_cdc_tog_rx_v1
    import ldl_cdc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEVEL = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       rx_clk,
    input  logic                       rx_rst,
    input  logic                       tx_st,
    input  logic [WIDTH-1:0]           din,
    output logic                       rx_st,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned LW = ldl_occ_width(DEPTH);
    localparam int unsigned PW = ldl_ptr_width(DEPTH);
    localparam logic [LW-1:0] DepthL = LW'(DEPTH);

    if (DEPTH < 1) begin : gen_depth_chk
        $fatal(1, "ldl_cdc_tog_rx_v1: DEPTH must be at least 1");
    end

    logic             t2r;
    logic             rx_st_q;
    logic             pending;
    logic             push;
    logic             pop;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // tx_st is sampled nowhere else; t2r is the only view of it in this domain.
    ldl_cdc_sync_v1 #(
        .LEVEL (LEVEL)
    ) u_sync_tx_st (
        .clk   (rx_clk),
        .rst_n (rx_rst),
        .d     (tx_st),
        .q     (t2r)
    );

    // A request is outstanding while the synchronised toggle differs from our ack.
    assign pending  = t2r ^ rx_st_q;
    assign dout_vld = (level_q != '0);
    assign pop      = dout_vld & dout_rdy;
    // A full buffer still accepts when the head leaves on the same edge.
    assign push     = pending & ((level_q < DepthL) | pop);

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = PW'(ldl_ptr_inc(ldl_cnt_t'(wr_ptr_q), DEPTH));
        end
        if (pop) begin
            rd_ptr_d = PW'(ldl_ptr_inc(ldl_cnt_t'(rd_ptr_q), DEPTH));
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            rx_st_q  <= 1'b0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // Copying t2r (rather than inverting) makes the ack toggle exactly once per word.
            if (push) begin
                rx_st_q <= t2r;
            end
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // din is only captured on push, by which time it has been stable for LEVEL edges.
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_ptr_q == PW'(i)) begin
                    mem_q[i] <= din;
                end
            end
        end
    end

    // Explicit compare-mux keeps the read in range for any DEPTH.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_ptr_q == PW'(i)) begin
                dout = mem_q[i];
            end
        end
    end

    assign rx_st = rx_st_q;
    assign busy  = pending;
    assign level = level_q;

endmodule
